// File: rtl/sw_test_status_mon.sv
// ============================================================================
// Module   : sw_test_status_mon
// Brief    : Multi-channel sw test status monitor with per-channel timeout and
//            registered aggregate done/pass/fail flags.
//            Optional WFI state enabled by `define SW_TEST_STATUS_WFI_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sw_test_status_mon #(
  parameter int unsigned                AddrWidth     = 32,
  parameter int unsigned                NumCh         = 2,
  parameter logic [AddrWidth-1:0]       StatusAddr    = 'h0041_1000,
  parameter logic [AddrWidth-1:0]       ChStride      = 'h0000_0100,
  parameter int unsigned                TimeoutCycles = 1_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_valid,
  input  logic [AddrWidth-1:0]  addr,
  input  logic [15:0]           data,
  output logic [3*NumCh-1:0]    ch_state_o,
  output logic [NumCh-1:0]      ch_done_o,
  output logic                  all_done_o,
  output logic                  all_pass_o,
  output logic                  any_fail_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BOOT    = 3'd1,
    S_TEST    = 3'd2,
    S_PASS    = 3'd3,
    S_FAIL    = 3'd4,
    S_TIMEOUT = 3'd5,
    S_WFI     = 3'd6
  } state_e;

  localparam int unsigned    TW      = (TimeoutCycles < 1) ? 1 : $clog2(TimeoutCycles + 1);
  localparam logic [TW-1:0]  TExp    = TW'(TimeoutCycles - 1);
  localparam logic [TW-1:0]  TMax    = '1;
  localparam logic           TimeoutEn = (TimeoutCycles != 0);

  logic [NumCh-1:0]   hit;
  logic [3*NumCh-1:0] st_d_vec;
  logic               is_boot, is_in_test, is_pass, is_fail, is_wfi;

  assign is_boot    = (data == 16'hb090);
  assign is_in_test = (data == 16'h4354);
  assign is_pass    = (data == 16'h900d);
  assign is_fail    = (data == 16'hbaad);
`ifdef SW_TEST_STATUS_WFI_EN
  assign is_wfi     = (data == 16'h1d1e);
`else
  assign is_wfi     = 1'b0;
`endif

  // One-hot decode; on aliased channel addresses the lowest index wins.
  always_comb begin
    logic found;
    hit   = '0;
    found = 1'b0;
    for (int c = 0; c < int'(NumCh); c++) begin
      if (!found && wr_valid &&
          addr == StatusAddr + ChStride * AddrWidth'(c)) begin
        hit[c] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NumCh; c++) begin : g_ch
    state_e         st_q, st_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic           terminal;

    assign terminal = (st_q == S_PASS) || (st_q == S_FAIL) || (st_q == S_TIMEOUT);

    always_comb begin
      st_d = st_q;
      if (!terminal) begin
        if (hit[c]) begin
          if (is_boot) begin
            st_d = S_BOOT;
          end else if (is_in_test) begin
            st_d = S_TEST;
          end else if (is_pass) begin
            st_d = (st_q == S_TEST || st_q == S_WFI) ? S_PASS : S_FAIL;
          end else if (is_fail) begin
            st_d = S_FAIL;
          end else if (is_wfi && st_q == S_TEST) begin
            st_d = S_WFI;
          end
        // A non-decoded hit at expiry only postpones the timeout by a cycle.
        end else if (TimeoutEn && st_q == S_TEST && tmr_q >= TExp) begin
          st_d = S_TIMEOUT;
        end
      end
    end

    always_comb begin
      tmr_d = '0;
      if (st_d == S_TEST) begin
        if (st_q == S_TEST && !(hit[c] && is_in_test)) begin
          tmr_d = (tmr_q == TMax) ? tmr_q : tmr_q + 1'b1;
        end
      end else if (st_d == S_WFI) begin
        tmr_d = tmr_q;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        st_q  <= S_IDLE;
        tmr_q <= '0;
      end else begin
        st_q  <= st_d;
        tmr_q <= tmr_d;
      end
    end

    assign st_d_vec[3*c +: 3]   = st_d;
    assign ch_state_o[3*c +: 3] = st_q;
    assign ch_done_o[c]         = terminal;
  end : g_ch

  logic all_done_d, all_pass_d, any_fail_d;
  logic all_done_q, all_pass_q, any_fail_q;

  // Aggregates come from next-state so they align with ch_state_o.
  always_comb begin
    logic [2:0] s;
    all_done_d = 1'b1;
    all_pass_d = 1'b1;
    any_fail_d = 1'b0;
    s          = 3'd0;
    for (int c = 0; c < int'(NumCh); c++) begin
      s = st_d_vec[3*c +: 3];
      if (!(s == S_PASS || s == S_FAIL || s == S_TIMEOUT)) all_done_d = 1'b0;
      if (s != S_PASS)                                     all_pass_d = 1'b0;
      if (s == S_FAIL || s == S_TIMEOUT)                   any_fail_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      all_done_q <= 1'b0;
      all_pass_q <= 1'b0;
      any_fail_q <= 1'b0;
    end else begin
      all_done_q <= all_done_d;
      all_pass_q <= all_pass_d;
      any_fail_q <= any_fail_d;
    end
  end

  assign all_done_o = all_done_q;
  assign all_pass_o = all_pass_q;
  assign any_fail_o = any_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_test_status_mon.sv
// ============================================================================
// Module   : tb_sw_test_status_mon
// Brief    : Self-checking bench for sw_test_status_mon: directed scenarios plus
//            randomized bus writes compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sw_test_status_mon;

  localparam int          NCH  = 3;
  localparam int          TOUT = 12;
  localparam logic [31:0] BASE = 32'h0041_1000;
  localparam logic [31:0] STRD = 32'h0000_0100;

  localparam int IDLE = 0, BOOT = 1, TEST = 2, PASS = 3, FAIL = 4, TMO = 5, WFI = 6;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              wr_valid = 1'b0;
  logic [31:0]       addr = '0;
  logic [15:0]       data = '0;
  logic [3*NCH-1:0]  ch_state_o;
  logic [NCH-1:0]    ch_done_o;
  logic              all_done_o, all_pass_o, any_fail_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: channel state and number of cycles spent in TEST since entry.
  int m_state [NCH];
  int m_age   [NCH];

  always #5 clk_i = ~clk_i;

  sw_test_status_mon #(
    .AddrWidth     (32),
    .NumCh         (NCH),
    .StatusAddr    (BASE),
    .ChStride      (STRD),
    .TimeoutCycles (TOUT)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .wr_valid   (wr_valid),
    .addr       (addr),
    .data       (data),
    .ch_state_o (ch_state_o),
    .ch_done_o  (ch_done_o),
    .all_done_o (all_done_o),
    .all_pass_o (all_pass_o),
    .any_fail_o (any_fail_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_term(input int s);
    return (s == PASS) || (s == FAIL) || (s == TMO);
  endfunction

  task automatic model_update(input logic v, input logic [31:0] a, input logic [15:0] d,
                              input logic r);
    int hc;
    if (r) begin
      for (int c = 0; c < NCH; c++) begin
        m_state[c] = IDLE;
        m_age[c]   = 0;
      end
      return;
    end
    hc = -1;
    for (int c = 0; c < NCH; c++)
      if (hc < 0 && v && a == BASE + STRD * c) hc = c;
    for (int c = 0; c < NCH; c++) begin
      if (is_term(m_state[c])) continue;
      if (c == hc) begin
        if (d == 16'hb090) begin
          m_state[c] = BOOT; m_age[c] = 0;
        end else if (d == 16'h4354) begin
          m_state[c] = TEST; m_age[c] = 0;
        end else if (d == 16'h900d) begin
          m_state[c] = (m_state[c] == TEST || m_state[c] == WFI) ? PASS : FAIL;
        end else if (d == 16'hbaad) begin
          m_state[c] = FAIL;
`ifdef SW_TEST_STATUS_WFI_EN
        end else if (d == 16'h1d1e && m_state[c] == TEST) begin
          m_state[c] = WFI;
`endif
        end else if (m_state[c] == TEST) begin
          m_age[c]++;
        end
      end else if (m_state[c] == TEST) begin
        if (m_age[c] >= TOUT - 1) m_state[c] = TMO;
        else                      m_age[c]++;
      end
    end
  endtask

  task automatic compare_all();
    logic [3*NCH-1:0] es;
    logic [NCH-1:0]   ed;
    bit ad, ap, af;
    ad = 1; ap = 1; af = 0;
    for (int c = 0; c < NCH; c++) begin
      es[3*c +: 3] = 3'(m_state[c]);
      ed[c]        = is_term(m_state[c]);
      ad &= is_term(m_state[c]);
      ap &= (m_state[c] == PASS);
      af |= (m_state[c] == FAIL || m_state[c] == TMO);
    end
    check_eq("ch_state", 64'(ch_state_o), 64'(es));
    check_eq("ch_done",  64'(ch_done_o),  64'(ed));
    check_eq("all_done", 64'(all_done_o), 64'(ad));
    check_eq("all_pass", 64'(all_pass_o), 64'(ap));
    check_eq("any_fail", 64'(any_fail_o), 64'(af));
  endtask

  // One clock: apply inputs, advance model at the edge, compare on the falling edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [15:0] d,
                      input logic r);
    wr_valid = v; addr = a; data = d; rst_i = r;
    @(posedge clk_i);
    model_update(v, a, d, r);
    @(negedge clk_i);
    compare_all();
  endtask

  task automatic wr(input int ch, input logic [15:0] d);
    step(1'b1, BASE + STRD * ch, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, '0, '0, 1'b1);
  endtask

  function automatic int ch_st(input int ch);
    return int'(ch_state_o[3*ch +: 3]);
  endfunction

  initial begin
    logic [15:0] codes [6];
    int          pick, ch;
    logic [15:0] d;
    codes[0] = 16'hb090; codes[1] = 16'h4354; codes[2] = 16'h900d;
    codes[3] = 16'hbaad; codes[4] = 16'h1d1e; codes[5] = 16'h1234;

    for (int c = 0; c < NCH; c++) begin m_state[c] = IDLE; m_age[c] = 0; end
    do_reset();
    do_reset();
    check_eq("rst_state", 64'(ch_state_o), 64'd0);

    // All channels boot, test and pass.
    for (int c = 0; c < NCH; c++) begin
      wr(c, 16'hb090); wr(c, 16'h4354); wr(c, 16'h900d);
    end
    check_eq("s1_all_pass", 64'(all_pass_o), 64'd1);
    check_eq("s1_all_done", 64'(all_done_o), 64'd1);

    // ch1 fails from TEST while others pass.
    do_reset();
    for (int c = 0; c < NCH; c++) begin wr(c, 16'hb090); wr(c, 16'h4354); end
    wr(0, 16'h900d); wr(2, 16'h900d); wr(1, 16'hbaad);
    check_eq("s2_ch1_fail", 64'(ch_st(1)), 64'(FAIL));
    check_eq("s2_any_fail", 64'(any_fail_o), 64'd1);
    check_eq("s2_not_pass", 64'(all_pass_o), 64'd0);

    // Timeout after TOUT cycles in TEST.
    do_reset();
    wr(0, 16'h4354);
    idle(TOUT - 1);
    check_eq("s3_pre_tmo", 64'(ch_st(0)), 64'(TEST));
    idle(1);
    check_eq("s3_tmo", 64'(ch_st(0)), 64'(TMO));

    // PASS in the expiry cycle beats the timeout.
    do_reset();
    wr(0, 16'h4354);
    idle(TOUT - 1);
    wr(0, 16'h900d);
    check_eq("s3_hit_wins", 64'(ch_st(0)), 64'(PASS));

    // PASS from BOOT is a protocol error; terminal state is sticky.
    do_reset();
    wr(0, 16'hb090); wr(0, 16'h900d);
    check_eq("s4_boot_pass", 64'(ch_st(0)), 64'(FAIL));
    wr(0, 16'h4354);
    check_eq("s4_sticky", 64'(ch_st(0)), 64'(FAIL));

    // Mid-test reset with a write in the reset cycle.
    do_reset();
    wr(0, 16'h4354); idle(7);
    step(1'b1, BASE, 16'h4354, 1'b1);
    check_eq("s5_rst_state", 64'(ch_state_o), 64'd0);
    check_eq("s5_rst_done",  64'(ch_done_o), 64'd0);

    // WFI code: holds the timer when enabled, ignored otherwise.
    do_reset();
    wr(0, 16'h4354); idle(5); wr(0, 16'h1d1e);
    idle(20);
`ifdef SW_TEST_STATUS_WFI_EN
    check_eq("s6_wfi", 64'(ch_st(0)), 64'(WFI));
    wr(0, 16'h4354);
    idle(TOUT - 1);
    check_eq("s6_timer_cleared", 64'(ch_st(0)), 64'(TEST));
`else
    check_eq("s6_no_wfi", 64'(ch_st(0)), 64'(TMO));
`endif

    // Randomized traffic, including unmapped addresses and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        step(1'($urandom_range(0, 1)), BASE, 16'h4354, 1'b1);
      end else if ($urandom_range(0, 9) < 3) begin
        pick = $urandom_range(0, 15);
        if      (pick < 3)  d = codes[0];
        else if (pick < 8)  d = codes[1];
        else if (pick < 10) d = codes[2];
        else if (pick < 11) d = codes[3];
        else if (pick < 13) d = codes[4];
        else if (pick < 14) d = codes[5];
        else                d = 16'($urandom);
        ch = $urandom_range(0, NCH);
        if ($urandom_range(0, 19) == 0) step(1'b1, $urandom, d, 1'b0);
        else                            step(1'b1, BASE + STRD * ch, d, 1'b0);
      end else begin
        step(1'($urandom_range(0, 3) == 0 ? 0 : 0), $urandom, 16'($urandom), 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
